// File: rtl/obi_sram_sbr.sv
// OBI subordinate backed by a word-addressed SRAM, with a fixed-latency response pipeline and an in-order response FIFO.
// Optional macro OBI_SBR_RREADY_EN makes rready_i apply backpressure; otherwise every response is presented for one cycle.
module obi_sram_sbr #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned NumWords       = 1024,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_i,
    output logic                                  gnt_o,
    input  logic [AddrWidth-1:0]                  addr_i,
    input  logic                                  we_i,
    input  logic [DataWidth/8-1:0]                be_i,
    input  logic [DataWidth-1:0]                  wdata_i,
    input  logic [IdWidth-1:0]                    aid_i,
    output logic                                  rvalid_o,
    input  logic                                  rready_i,
    output logic [DataWidth-1:0]                  rdata_o,
    output logic [IdWidth-1:0]                    rid_o,
    output logic                                  err_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);

    localparam int unsigned BeWidth  = DataWidth / 8;
    localparam int unsigned OffBits  = $clog2(BeWidth);
    localparam int unsigned IdxWidth = AddrWidth - OffBits;
    localparam int unsigned MemAw    = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned PtrW     = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);

    logic [DataWidth-1:0] mem_q [NumWords];

    logic [IdxWidth-1:0]  wordIdx;
    logic [MemAw-1:0]     memAddr;
    logic                 inRange;
    logic                 handshake;
    logic [DataWidth-1:0] newData;
    logic                 newErr;

    logic                 pipeValid_q [Latency];
    logic [IdWidth-1:0]   pipeId_q    [Latency];
    logic [DataWidth-1:0] pipeData_q  [Latency];
    logic                 pipeErr_q   [Latency];

    logic [IdWidth-1:0]   fifoId_q    [MaxOutstanding];
    logic [DataWidth-1:0] fifoData_q  [MaxOutstanding];
    logic                 fifoErr_q   [MaxOutstanding];
    logic [PtrW-1:0]      rdPtr_q, wrPtr_q;
    logic [CntW-1:0]      fifoCount_q;
    logic [CntW-1:0]      outstanding_q;

    logic                 lastValid;
    logic                 headValid;
    logic                 fifoFull;
    logic                 rvalid;
    logic                 retire;
    logic                 fifoPush;
    logic                 fifoPop;
    logic                 unusedBits;

    function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign wordIdx   = addr_i[AddrWidth-1:OffBits];
    assign memAddr   = wordIdx[MemAw-1:0];
    assign inRange   = wordIdx < IdxWidth'(NumWords);
    assign gnt_o     = req_i && (outstanding_q < CntW'(MaxOutstanding));
    assign handshake = req_i && gnt_o;
    assign newErr    = !inRange;
    assign newData   = (we_i || !inRange) ? '0 : mem_q[memAddr];

    always_ff @(posedge clk_i) begin
        if (handshake && we_i && inRange) begin
            for (int k = 0; k < BeWidth; k++) begin
                if (be_i[k]) mem_q[memAddr][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
    end

    // Only the valid bits need clearing; payloads are masked by rvalid at the output.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < Latency; i++) pipeValid_q[i] <= 1'b0;
        end else begin
            pipeValid_q[0] <= handshake;
            for (int i = 1; i < Latency; i++) pipeValid_q[i] <= pipeValid_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        pipeId_q[0]   <= aid_i;
        pipeData_q[0] <= newData;
        pipeErr_q[0]  <= newErr;
        for (int i = 1; i < Latency; i++) begin
            pipeId_q[i]   <= pipeId_q[i-1];
            pipeData_q[i] <= pipeData_q[i-1];
            pipeErr_q[i]  <= pipeErr_q[i-1];
        end
    end

    assign lastValid = pipeValid_q[Latency-1];
    assign headValid = fifoCount_q != '0;
    assign fifoFull  = fifoCount_q == CntW'(MaxOutstanding);
    assign rvalid    = headValid || lastValid;

`ifdef OBI_SBR_RREADY_EN
    assign retire     = rvalid && rready_i;
    assign unusedBits = ^addr_i[OffBits-1:0];
`else
    assign retire     = rvalid;
    assign unusedBits = ^{addr_i[OffBits-1:0], rready_i};
`endif

    // The pipeline output bypasses the FIFO when it is empty and retires immediately.
    assign fifoPop  = headValid && retire;
    assign fifoPush = lastValid && (headValid || !retire);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdPtr_q       <= '0;
            wrPtr_q       <= '0;
            fifoCount_q   <= '0;
            outstanding_q <= '0;
        end else begin
            if (fifoPush) wrPtr_q <= incPtr(wrPtr_q);
            if (fifoPop)  rdPtr_q <= incPtr(rdPtr_q);
            fifoCount_q   <= fifoCount_q + CntW'(fifoPush) - CntW'(fifoPop);
            outstanding_q <= outstanding_q + CntW'(handshake) - CntW'(retire);
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifoPush) begin
            fifoId_q[wrPtr_q]   <= pipeId_q[Latency-1];
            fifoData_q[wrPtr_q] <= pipeData_q[Latency-1];
            fifoErr_q[wrPtr_q]  <= pipeErr_q[Latency-1];
        end
    end

    always_comb begin
        rid_o   = '0;
        rdata_o = '0;
        err_o   = 1'b0;
        if (headValid) begin
            rid_o   = fifoId_q[rdPtr_q];
            rdata_o = fifoData_q[rdPtr_q];
            err_o   = fifoErr_q[rdPtr_q];
        end else if (lastValid) begin
            rid_o   = pipeId_q[Latency-1];
            rdata_o = pipeData_q[Latency-1];
            err_o   = pipeErr_q[Latency-1];
        end
    end

    assign rvalid_o      = rvalid;
    assign outstanding_o = outstanding_q;

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(fifoPush && fifoFull))
        else $fatal(1, "obi_sram_sbr: push into full response FIFO");

endmodule

// File: tb/tb_obi_sram_sbr.sv
// Directed self-checking bench for obi_sram_sbr (Latency=3, default sizes).
// The backpressure scenario runs only when OBI_SBR_RREADY_EN is defined.
module tb_obi_sram_sbr;

    localparam int L = 3;

    logic        clk;
    logic        rst_ni;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [3:0]  aid;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [3:0]  rid;
    logic        err;
    logic [2:0]  outstanding;

    int testsRun    = 0;
    int testsFailed = 0;

    obi_sram_sbr #(.Latency(L)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(gnt),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata), .aid_i(aid),
        .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rid_o(rid),
        .err_o(err), .outstanding_o(outstanding)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction: grant now, nothing until handshake+L, one response, then idle.
    task automatic applyStimulus(input logic weIn, input logic [31:0] addrIn, input logic [7:0] beIn,
                                 input logic [63:0] wdataIn, input logic [3:0] aidIn,
                                 input logic [63:0] expData, input logic expErr);
        req = 1'b1; we = weIn; addr = addrIn; be = beIn; wdata = wdataIn; aid = aidIn;
        #1;
        checkOutput("gnt", gnt, 1);
        stepCycle();
        req = 1'b0;
        for (int i = 1; i < L; i++) begin
            checkOutput("early_rvalid", rvalid, 0);
            stepCycle();
        end
        checkOutput("rvalid", rvalid, 1);
        checkOutput("rid", rid, aidIn);
        checkOutput("rdata", rdata, expData);
        checkOutput("err", err, expErr);
        stepCycle();
        checkOutput("rvalid_after", rvalid, 0);
        checkOutput("outst_idle", outstanding, 0);
    endtask

    function automatic logic [63:0] pat(input int i);
        return {32'hC0DE0000 + 32'(i), 32'h12340000 + 32'(i)};
    endfunction

    initial begin
        int granted;
        int retired;
        int expOut;
        req = 0; we = 0; addr = 0; be = 0; wdata = 0; aid = 0; rready = 1; rst_ni = 0;
        stepCycle();
        stepCycle();
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_outst", outstanding, 0);
        checkOutput("rst_rid", rid, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_err", err, 0);
        rst_ni = 1;
        stepCycle();

        // Full write then read, partial write, zero-enable write, ignored low address bits
        applyStimulus(1, 32'h10, 8'hFF, 64'h1122334455667788, 4'd3, 64'h0, 0);
        applyStimulus(0, 32'h10, 8'h00, 64'h0, 4'd5, 64'h1122334455667788, 0);
        applyStimulus(1, 32'h10, 8'h0F, 64'hAAAAAAAABBBBBBBB, 4'd1, 64'h0, 0);
        applyStimulus(0, 32'h10, 8'hFF, 64'h0, 4'd2, 64'h11223344BBBBBBBB, 0);
        applyStimulus(1, 32'h10, 8'h00, 64'hFFFFFFFFFFFFFFFF, 4'd4, 64'h0, 0);
        applyStimulus(0, 32'h17, 8'h01, 64'h0, 4'd6, 64'h11223344BBBBBBBB, 0);

        // Out-of-range accesses must not alias onto word 0 or touch the top word
        applyStimulus(1, 32'h1FF8, 8'hFF, 64'hDEADBEEFCAFEF00D, 4'd7, 64'h0, 0);
        applyStimulus(1, 32'h0, 8'hFF, 64'h0102030405060708, 4'd8, 64'h0, 0);
        applyStimulus(0, 32'h2000, 8'hFF, 64'h0, 4'd9, 64'h0, 1);
        applyStimulus(1, 32'h2000, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 4'd10, 64'h0, 1);
        applyStimulus(0, 32'h0, 8'hFF, 64'h0, 4'd11, 64'h0102030405060708, 0);
        applyStimulus(0, 32'h1FF8, 8'hFF, 64'h0, 4'd12, 64'hDEADBEEFCAFEF00D, 0);

        for (int i = 0; i < 6; i++)
            applyStimulus(1, 32'h200 + 32'(8*i), 8'hFF, pat(i), 4'(i), 64'h0, 0);

        // Back-to-back reads, one per cycle
        for (int c = 0; c <= 6 + L; c++) begin
            if (c < 6) begin
                req = 1; we = 0; be = 8'hFF; addr = 32'h200 + 32'(8*c); aid = 4'(c);
            end else begin
                req = 0;
            end
            #1;
            if (c < 6) checkOutput("b2b_gnt", gnt, 1);
            expOut = ((c < 6) ? c : 6) - ((c - L < 0) ? 0 : ((c - L > 6) ? 6 : c - L));
            checkOutput("b2b_outst", outstanding, 64'(expOut));
            checkOutput("b2b_rvalid", rvalid, (c >= L && c < L + 6) ? 1 : 0);
            if (c >= L && c < L + 6) begin
                checkOutput("b2b_rid", rid, 64'(c - L));
                checkOutput("b2b_rdata", rdata, pat(c - L));
            end
            stepCycle();
        end

`ifdef OBI_SBR_RREADY_EN
        // Backpressure: credits run out after four grants and the head is held
        rready = 0;
        granted = 0;
        for (int c = 0; c < 10; c++) begin
            req = (granted < 6); we = 0; be = 8'hFF;
            addr = 32'h200 + 32'(8*granted); aid = 4'(granted);
            #1;
            if (c >= L) begin
                checkOutput("bp_hold_rvalid", rvalid, 1);
                checkOutput("bp_hold_rid", rid, 0);
            end
            if (gnt) granted++;
            stepCycle();
        end
        checkOutput("bp_grants", 64'(granted), 4);
        checkOutput("bp_gnt_low", gnt, 0);
        checkOutput("bp_outst", outstanding, 4);
        checkOutput("bp_head_data", rdata, pat(0));
        rready = 1;
        retired = 0;
        for (int c = 0; c < 30; c++) begin
            req = (granted < 6); we = 0; be = 8'hFF;
            addr = 32'h200 + 32'(8*granted); aid = 4'(granted);
            #1;
            if (rvalid) begin
                checkOutput("drain_rid", rid, 64'(retired));
                checkOutput("drain_rdata", rdata, pat(retired));
                retired++;
            end
            if (gnt) granted++;
            stepCycle();
        end
        req = 0;
        checkOutput("drain_grants", 64'(granted), 6);
        checkOutput("drain_retired", 64'(retired), 6);
        checkOutput("drain_outst", outstanding, 0);
`endif

        // Reset with three transactions in flight
        for (int c = 0; c < 3; c++) begin
            req = 1; we = 0; be = 8'hFF; addr = 32'h10; aid = 4'(7 + c);
            stepCycle();
        end
        req = 0;
        checkOutput("pre_rst_outst", outstanding, 3);
        rst_ni = 0;
        stepCycle();
        rst_ni = 1;
        checkOutput("mid_rst_rvalid", rvalid, 0);
        checkOutput("mid_rst_outst", outstanding, 0);
        checkOutput("mid_rst_rid", rid, 0);
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            checkOutput("post_rst_quiet", rvalid, 0);
        end
        applyStimulus(0, 32'h10, 8'hFF, 64'h0, 4'd2, 64'h11223344BBBBBBBB, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
